// File: rtl/ppu_vram_arbiter.sv
// Arbitrates the PPU's single-port VRAM between the colour loader, the render fetcher and the CPU
// PPUDATA port: one access per clock, with read data returned and tagged RD_LAT cycles later.
module ppu_vram_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        req_color,
  input  logic [15:0] addr_color,
  input  logic        req_rend,
  input  logic [15:0] addr_rend,
  input  logic        req_cpu,
  input  logic [15:0] addr_cpu,
  input  logic        we_cpu,
  input  logic [7:0]  wdata_cpu,
  output logic        gnt_color,
  output logic        gnt_rend,
  output logic        gnt_cpu,
  output logic        rvalid_color,
  output logic        rvalid_rend,
  output logic        rvalid_cpu,
  output logic [7:0]  rdata,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic        cpu_wait_sat
);

  localparam logic [1:0] ID_COLOR = 2'd0;
  localparam logic [1:0] ID_REND  = 2'd1;
  localparam logic [1:0] ID_CPU   = 2'd2;
  localparam logic [7:0] SAT_LVL  = 8'(STARVE_MAX);

  logic        elig_color, elig_rend, elig_cpu, cpu_first;
  logic        win_any;
  logic [1:0]  win_id;
  logic [15:0] nxt_addr;
  logic        nxt_we;
  logic [7:0]  nxt_wdata;
  logic        issue_rd;
  logic [1:0]  issue_id;
  logic        tag_v  [RD_LAT];
  logic [1:0]  tag_id [RD_LAT];
  logic [7:0]  wait_cnt;

  // req/gnt handshake: a requester raises req with addr/we/wdata stable; gnt pulses for one
  // cycle right after the accepting edge. A req whose gnt is high this cycle is not eligible,
  // so a held req is served at most every other cycle; the requester may change its command
  // or drop req during the gnt cycle.
  assign elig_color = req_color & ~gnt_color;
  assign elig_rend  = req_rend  & ~gnt_rend;
  assign elig_cpu   = req_cpu   & ~gnt_cpu;
  assign cpu_first  = vblank | cpu_wait_sat;

  // When the CPU is not promoted, its branch at the end is the lowest priority.
  always_comb begin
    win_any = 1'b1;
    win_id  = ID_COLOR;
    if (cpu_first && elig_cpu) win_id = ID_CPU;
    else if (elig_color)       win_id = ID_COLOR;
    else if (elig_rend)        win_id = ID_REND;
    else if (elig_cpu)         win_id = ID_CPU;
    else                       win_any = 1'b0;
  end

  always_comb begin
    nxt_addr  = vram_addr;
    nxt_we    = 1'b0;
    nxt_wdata = vram_wdata;
    if (win_any) begin
      case (win_id)
        ID_COLOR: nxt_addr = addr_color;
        ID_REND:  nxt_addr = addr_rend;
        default: begin
          nxt_addr  = addr_cpu;
          nxt_we    = we_cpu;
          nxt_wdata = wdata_cpu;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_color  <= 1'b0;
      gnt_rend   <= 1'b0;
      gnt_cpu    <= 1'b0;
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
    end else begin
      gnt_color  <= win_any && (win_id == ID_COLOR);
      gnt_rend   <= win_any && (win_id == ID_REND);
      gnt_cpu    <= win_any && (win_id == ID_CPU);
      vram_addr  <= nxt_addr;
      vram_we    <= nxt_we;
      vram_wdata <= nxt_wdata;
    end
  end

  // The access issued this cycle is the one whose gnt is high; only reads enter a valid tag.
  assign issue_rd = (gnt_color | gnt_rend | gnt_cpu) & ~vram_we;
  assign issue_id = gnt_cpu ? ID_CPU : (gnt_rend ? ID_REND : ID_COLOR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= ID_COLOR;
      end
    end else begin
      tag_v[0]  <= issue_rd;
      tag_id[0] <= issue_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rvalid_color = tag_v[RD_LAT-1] && (tag_id[RD_LAT-1] == ID_COLOR);
  assign rvalid_rend  = tag_v[RD_LAT-1] && (tag_id[RD_LAT-1] == ID_REND);
  assign rvalid_cpu   = tag_v[RD_LAT-1] && (tag_id[RD_LAT-1] == ID_CPU);
  assign rdata        = vram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!req_cpu || gnt_cpu) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign cpu_wait_sat = (wait_cnt >= SAT_LVL);

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: two builds (RD_LAT=1 and RD_LAT=3) share the same stimulus and are
// checked every cycle against a transaction-level model, plus hand-computed directed expectations.
module tb_ppu_vram_arbiter;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;
  localparam int STARVE = 32;
  localparam int MEM_N  = 65536;

  typedef struct packed { logic v; logic [1:0] id; logic [7:0] data; } rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        vblank, req_color, req_rend, req_cpu, we_cpu;
  logic [15:0] addr_color, addr_rend, addr_cpu;
  logic [7:0]  wdata_cpu;

  logic [2:0]  a_gnt, a_rv, b_gnt, b_rv;
  logic [7:0]  a_rdata, b_rdata, a_vwdata, b_vwdata, a_vrdata, b_vrdata;
  logic [15:0] a_vaddr, b_vaddr;
  logic        a_vwe, b_vwe, a_sat, b_sat;

  int total = 0;
  int bad   = 0;

  ppu_vram_arbiter #(.RD_LAT(LAT_A), .STARVE_MAX(STARVE)) dut_a (
    .clk(clk), .rst(rst), .vblank(vblank),
    .req_color(req_color), .addr_color(addr_color),
    .req_rend(req_rend), .addr_rend(addr_rend),
    .req_cpu(req_cpu), .addr_cpu(addr_cpu), .we_cpu(we_cpu), .wdata_cpu(wdata_cpu),
    .gnt_color(a_gnt[0]), .gnt_rend(a_gnt[1]), .gnt_cpu(a_gnt[2]),
    .rvalid_color(a_rv[0]), .rvalid_rend(a_rv[1]), .rvalid_cpu(a_rv[2]),
    .rdata(a_rdata), .vram_addr(a_vaddr), .vram_we(a_vwe), .vram_wdata(a_vwdata),
    .vram_rdata(a_vrdata), .cpu_wait_sat(a_sat)
  );

  ppu_vram_arbiter #(.RD_LAT(LAT_B), .STARVE_MAX(STARVE)) dut_b (
    .clk(clk), .rst(rst), .vblank(vblank),
    .req_color(req_color), .addr_color(addr_color),
    .req_rend(req_rend), .addr_rend(addr_rend),
    .req_cpu(req_cpu), .addr_cpu(addr_cpu), .we_cpu(we_cpu), .wdata_cpu(wdata_cpu),
    .gnt_color(b_gnt[0]), .gnt_rend(b_gnt[1]), .gnt_cpu(b_gnt[2]),
    .rvalid_color(b_rv[0]), .rvalid_rend(b_rv[1]), .rvalid_cpu(b_rv[2]),
    .rdata(b_rdata), .vram_addr(b_vaddr), .vram_we(b_vwe), .vram_wdata(b_vwdata),
    .vram_rdata(b_vrdata), .cpu_wait_sat(b_sat)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'(a >> 8);
  endfunction

  // ---------------- VRAM macros (one per build) ----------------
  logic [7:0] mem_a [MEM_N];
  logic [7:0] mem_b [MEM_N];
  logic [7:0] pipe_a [LAT_A];
  logic [7:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_N; i++) mem_a[i] <= init_val(i);
    end else begin
      if (a_vwe) mem_a[a_vaddr] <= a_vwdata;
      pipe_a[0] <= mem_a[a_vaddr];
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign a_vrdata = pipe_a[LAT_A-1];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_N; i++) mem_b[i] <= init_val(i);
    end else begin
      if (b_vwe) mem_b[b_vaddr] <= b_vwdata;
      pipe_b[0] <= mem_b[b_vaddr];
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign b_vrdata = pipe_b[LAT_B-1];

  // ---------------- transaction-level model ----------------
  logic [7:0]  ref_mem [MEM_N];
  logic [2:0]  m_gnt;
  int          m_cnt;
  logic [15:0] m_addr;
  logic        m_we;
  logic [7:0]  m_wdata;
  rec_t        hist [5];
  logic [2:0]  m_elig;
  logic        m_top;
  int          m_win;
  int          who;
  logic [15:0] m_win_addr;

  // Rank order: 0=colour,1=render,2=cpu; with the CPU on top the rotation is 2,0,1.
  always_comb begin
    m_elig = {req_cpu & ~m_gnt[2], req_rend & ~m_gnt[1], req_color & ~m_gnt[0]};
    m_top  = vblank || (m_cnt >= STARVE);
    m_win  = -1;
    who    = 0;
    for (int k = 0; k < 3; k++) begin
      who = m_top ? (k + 2) % 3 : k;
      if (m_win < 0 && m_elig[who]) m_win = who;
    end
    case (m_win)
      0:       m_win_addr = addr_color;
      1:       m_win_addr = addr_rend;
      default: m_win_addr = addr_cpu;
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_gnt   <= '0;
      m_cnt   <= 0;
      m_addr  <= '0;
      m_we    <= 1'b0;
      m_wdata <= '0;
      for (int i = 0; i < 5; i++) hist[i] <= '0;
      for (int i = 0; i < MEM_N; i++) ref_mem[i] <= init_val(i);
    end else begin
      m_cnt <= (!req_cpu || m_gnt[2]) ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
      hist[0] <= '0;
      m_gnt   <= '0;
      m_we    <= 1'b0;
      if (m_win >= 0) begin
        m_gnt[m_win] <= 1'b1;
        m_addr       <= m_win_addr;
        if (m_win == 2 && we_cpu) begin
          m_we             <= 1'b1;
          m_wdata          <= wdata_cpu;
          ref_mem[addr_cpu] <= wdata_cpu;
        end else begin
          hist[0] <= {1'b1, 2'(m_win), ref_mem[m_win_addr]};
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input logic [2:0] gnt, input logic [2:0] rv,
                            input logic [7:0] rd, input logic [15:0] vaddr, input logic vwe,
                            input logic [7:0] vwdata, input logic sat, input int lat);
    logic [2:0] exp_rv;
    exp_rv = hist[lat].v ? 3'(1 << hist[lat].id) : 3'b000;
    chk({nm, ".gnt"}, 32'(gnt), 32'(m_gnt));
    chk({nm, ".rvalid"}, 32'(rv), 32'(exp_rv));
    if (exp_rv != 3'b000) chk({nm, ".rdata"}, 32'(rd), 32'(hist[lat].data));
    chk({nm, ".wait_sat"}, 32'(sat), (m_cnt >= STARVE) ? 1 : 0);
    chk({nm, ".vram_we"}, 32'(vwe), 32'(m_we));
    chk({nm, ".vram_addr"}, 32'(vaddr), 32'(m_addr));
    if (m_we || !rst) chk({nm, ".vram_wdata"}, 32'(vwdata), 32'(m_wdata));
  endtask

  always @(negedge clk) begin
    check_inst("a", a_gnt, a_rv, a_rdata, a_vaddr, a_vwe, a_vwdata, a_sat, LAT_A);
    check_inst("b", b_gnt, b_rv, b_rdata, b_vaddr, b_vwe, b_vwdata, b_sat, LAT_B);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_color = 1'b0; req_rend = 1'b0; req_cpu = 1'b0; we_cpu = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int sat_at;
    vblank = 1'b0; idle();
    addr_color = '0; addr_rend = '0; addr_cpu = '0; wdata_cpu = '0;

    repeat (2) @(negedge clk);
    chk("reset.gnt", 32'(a_gnt), 0);
    chk("reset.rvalid", 32'(a_rv), 0);
    chk("reset.vram_we", 32'(a_vwe), 0);
    chk("reset.vram_addr", 32'(a_vaddr), 0);
    chk("reset.vram_wdata", 32'(a_vwdata), 0);
    chk("reset.wait_sat", 32'(a_sat), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Normal priority: colour > render > CPU, each released in its grant cycle.
    req_color = 1'b1; addr_color = 16'h3F01;
    req_rend  = 1'b1; addr_rend  = 16'h2000;
    req_cpu   = 1'b1; addr_cpu   = 16'h2100; we_cpu = 1'b0;
    tick(); req_color = 1'b0;
    @(negedge clk); chk("prio.gnt1", 32'(a_gnt), 'h1);
    tick(); req_rend = 1'b0;
    @(negedge clk); chk("prio.gnt2", 32'(a_gnt), 'h2);
    chk("prio.rv_color", 32'(a_rv), 'h1); chk("prio.rd_color", 32'(a_rdata), 'h3E);
    tick(); req_cpu = 1'b0;
    @(negedge clk); chk("prio.gnt3", 32'(a_gnt), 'h4);
    chk("prio.rv_rend", 32'(a_rv), 'h2); chk("prio.rd_rend", 32'(a_rdata), 'h20);
    tick();
    @(negedge clk); chk("prio.rv_cpu", 32'(a_rv), 'h4); chk("prio.rd_cpu", 32'(a_rdata), 'h21);
    repeat (3) tick();

    // vblank: CPU first; its write is visible to the colour read that follows.
    vblank = 1'b1;
    req_cpu = 1'b1; addr_cpu = 16'h3F00; we_cpu = 1'b1; wdata_cpu = 8'h0F;
    req_color = 1'b1; addr_color = 16'h3F00;
    req_rend = 1'b1; addr_rend = 16'h2001;
    tick(); req_cpu = 1'b0; we_cpu = 1'b0;
    @(negedge clk); chk("vbl.gnt1", 32'(a_gnt), 'h4);
    chk("vbl.we", 32'(a_vwe), 1); chk("vbl.addr", 32'(a_vaddr), 'h3F00);
    tick(); req_color = 1'b0;
    @(negedge clk); chk("vbl.gnt2", 32'(a_gnt), 'h1);
    tick(); req_rend = 1'b0; vblank = 1'b0;
    @(negedge clk); chk("vbl.gnt3", 32'(a_gnt), 'h2);
    chk("vbl.rv_color", 32'(a_rv), 'h1); chk("vbl.rd_color", 32'(a_rdata), 'h0F);
    tick();
    @(negedge clk); chk("vbl.rv_rend", 32'(a_rv), 'h2); chk("vbl.rd_rend", 32'(a_rdata), 'h21);
    repeat (3) tick();

    // Starvation: colour and render keep the port busy while the CPU waits.
    req_cpu = 1'b1; addr_cpu = 16'h2200; we_cpu = 1'b0;
    req_color = 1'b1; addr_color = 16'h3F10;
    req_rend = 1'b1; addr_rend = 16'h2300;
    sat_at = 0;
    for (int i = 1; i <= 40 && sat_at == 0; i++) begin
      tick();
      @(negedge clk);
      if (a_sat) sat_at = i;
    end
    chk("starve.sat_cycle", sat_at, 32);
    tick();
    @(negedge clk); chk("starve.gnt_cpu", 32'(a_gnt), 'h4); chk("starve.sat_hold", 32'(a_sat), 1);
    tick();
    @(negedge clk); chk("starve.sat_fall", 32'(a_sat), 0); chk("starve.no_regrant", 32'(a_gnt[2]), 0);
    idle();
    repeat (4) tick();

    // Held render request with a fresh address after each grant.
    req_rend = 1'b1; addr_rend = 16'h2400;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("held.gnt_rend", 32'(a_gnt[1]), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) addr_rend = addr_rend + 16'd1;
    end
    req_rend = 1'b0;
    repeat (3) tick();

    // Interleaved render/CPU reads, checked on both latency builds.
    req_rend = 1'b1; addr_rend = 16'h2500;
    req_cpu = 1'b1; addr_cpu = 16'h2680; we_cpu = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("ilv.gnt", 32'(a_gnt), (i % 2 == 0) ? 'h2 : 'h4);
      if (i >= 1) chk("ilv.a_rv", 32'(a_rv), ((i - 1) % 2 == 0) ? 'h2 : 'h4);
      if (i >= 3) chk("ilv.b_rv", 32'(b_rv), ((i - 3) % 2 == 0) ? 'h2 : 'h4);
      if (i % 2 == 0) addr_rend = addr_rend + 16'd3;
      else addr_cpu = addr_cpu + 16'd5;
    end
    idle();
    repeat (5) tick();

    // Reset while a render read is in flight.
    req_rend = 1'b1; addr_rend = 16'h2000;
    tick(); req_rend = 1'b0;
    @(negedge clk); chk("rstmid.gnt", 32'(a_gnt), 'h2);
    #1 rst = 1'b0;
    req_color = 1'b1; addr_color = 16'h3F05;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid.a_rv", 32'(a_rv), 0);
      chk("rstmid.b_rv", 32'(b_rv), 0);
      chk("rstmid.addr", 32'(a_vaddr), 0);
      chk("rstmid.gnt", 32'(a_gnt), 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    tick(); req_color = 1'b0;
    @(negedge clk); chk("rstmid.first_gnt", 32'(a_gnt), 'h1);
    tick();
    @(negedge clk); chk("rstmid.rv_color", 32'(a_rv), 'h1); chk("rstmid.rd_color", 32'(a_rdata), 'h3A);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
